// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub
// Description : Multi-cycle integer adder/subtractor. One 4-bit nibble is
//               processed per clock, LSB nibble first, with the slice carry
//               chained through a carry register. The input and output sides
//               each use a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub #(
    parameter int WIDTH = 32            // multiple of 4, at least 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_busy
);

    localparam int c_nib   = WIDTH / 4;
    localparam int c_cnt_w = (c_nib > 1) ? $clog2(c_nib) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nib - 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;        // shifts right one nibble per RUN cycle
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;      // result nibbles shift in from the top
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [4:0]         w_sum;
    logic [3:0]         w_low3;
    logic               w_c_msb;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_last;

    // Nibble slice: B is inverted for subtraction and the carry register
    // supplies the +1 on the first nibble.
    always_comb begin
        w_a_nib   = r_a[3:0];
        w_b_nib   = r_b[3:0] ^ {4{r_sub}};
        w_sum     = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        // Carry into the nibble's top bit; on the last nibble this is the
        // carry into the operand MSB used for signed overflow.
        w_low3    = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
        w_c_msb   = w_low3[3];
        w_acc_nxt = {w_sum[3:0], r_acc[WIDTH-1:4]};
        w_last    = (r_cnt == c_last);
    end

    // Control FSM and datapath registers; result flags only update on the
    // final nibble so they hold their values outside DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= c_s_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_sub   <= i_sub;
                        r_carry <= i_sub;
                        r_cnt   <= '0;
                        r_state <= c_s_run;
                    end
                end
                c_s_run: begin
                    r_a     <= {4'b0000, r_a[WIDTH-1:4]};
                    r_b     <= {4'b0000, r_b[WIDTH-1:4]};
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_sum[4];
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_cout   <= w_sum[4] ^ r_sub;
                        r_ovf    <= w_c_msb ^ w_sum[4];
                        r_zero   <= (w_acc_nxt == '0);
                        r_state  <= c_s_done;
                    end
                end
                c_s_done: begin
                    if (i_ready) begin
                        r_state <= c_s_idle;
                    end
                end
                default: r_state <= c_s_idle;
            endcase
        end
    end

    assign o_ready  = (r_state == c_s_idle);
    assign o_valid  = (r_state == c_s_done);
    assign o_busy   = (r_state != c_s_idle);
    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_ovf    = r_ovf;
    assign o_zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_addsub
// Description : Directed, table-driven bench for nibble_serial_addsub
//               (WIDTH = 32) plus hand-written handshake/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             i_clk;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;
    logic             o_busy;

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sub    (i_sub),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [9];
    vec_t b2b  [4];

    int n_vec;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one operation, waits for the accept edge and then for o_valid.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sub, output int lat);
        @(negedge i_clk);
        i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
        chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input int lat);
        chk("latency", lat, NIB);
        chk("valid",   {31'd0, o_valid}, 32'd1);
        chk("result",  o_result, v.res);
        chk("cout",    {31'd0, o_cout}, {31'd0, v.cout});
        chk("ovf",     {31'd0, o_ovf},  {31'd0, v.ovf});
        chk("zero",    {31'd0, o_zero}, {31'd0, v.zero});
        chk("busy_done",  {31'd0, o_busy},  32'd1);
        chk("ready_done", {31'd0, o_ready}, 32'd0);
    endtask

    task automatic release_out();
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("valid_after_hs", {31'd0, o_valid}, 32'd0);
        chk("ready_after_hs", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        int   acc_cyc [4];
        int   n_acc;
        int   n_res;
        logic adv;
        vec_t v;

        n_vec = 0; n_fail = 0;
        //            a             b             sub   result        cout  ovf   zero
        vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h89ABCDEF, 32'h76543210, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h00000003, 32'hFFFFFFFE, 1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0};

        b2b[0]  = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0};
        b2b[1]  = '{32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b0, 1'b0, 1'b0};
        b2b[2]  = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        b2b[3]  = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};

        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_sub = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Reset state
        chk("rst_valid",  {31'd0, o_valid}, 32'd0);
        chk("rst_ready",  {31'd0, o_ready}, 32'd1);
        chk("rst_busy",   {31'd0, o_busy},  32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_flags",  {29'd0, o_cout, o_ovf, o_zero}, 32'd0);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            check_result(vecs[i], lat);
            release_out();
        end

        // Backpressure: hold DONE for 10 cycles while new requests arrive
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        check_result(vecs[3], lat);
        for (int k = 0; k < 10; k++) begin
            i_valid = ~i_valid;
            i_a = $urandom; i_b = $urandom; i_sub = k[0];
            @(negedge i_clk);
            chk("bp_valid",  {31'd0, o_valid}, 32'd1);
            chk("bp_ready",  {31'd0, o_ready}, 32'd0);
            chk("bp_result", o_result, 32'h80000000);
            chk("bp_flags",  {29'd0, o_cout, o_ovf, o_zero}, 32'b010);
        end
        i_valid = 1'b0;
        release_out();

        // Reset during RUN on nibble 3 aborts the operation silently
        @(negedge i_clk);
        i_a = 32'h11111111; i_b = 32'h22222222; i_sub = 1'b0; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("abort_ready", {31'd0, o_ready}, 32'd1);
        chk("abort_busy",  {31'd0, o_busy},  32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < NIB + 4; k++) begin
                @(negedge i_clk);
                if (o_valid) seen++;
            end
            chk("abort_no_valid", seen, 0);
        end
        v = '{32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b0, 1'b0};
        start_op(v.a, v.b, v.sub, lat);
        check_result(v, lat);

        // Reset and output handshake on the same edge: reset clears the result
        i_ready = 1'b1; i_reset = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0; i_reset = 1'b0;
        chk("rst_hs_result", o_result, 32'd0);
        chk("rst_hs_valid",  {31'd0, o_valid}, 32'd0);

        // Reset together with an input request: no operation starts
        i_valid = 1'b1; i_reset = 1'b1; i_a = 32'h5; i_b = 32'h6;
        @(negedge i_clk);
        i_valid = 1'b0; i_reset = 1'b0;
        chk("rst_req_busy", {31'd0, o_busy}, 32'd0);

        // Back-to-back: i_valid held high, i_ready tied high
        i_ready = 1'b1;
        n_acc = 0; n_res = 0; adv = 1'b0;
        @(negedge i_clk);
        i_a = b2b[0].a; i_b = b2b[0].b; i_sub = b2b[0].sub; i_valid = 1'b1;
        for (int cyc = 0; cyc < 6 * (NIB + 2); cyc++) begin
            if (adv) begin
                adv = 1'b0;
                if (n_acc < 4) begin
                    i_a = b2b[n_acc].a; i_b = b2b[n_acc].b; i_sub = b2b[n_acc].sub;
                end else begin
                    i_valid = 1'b0;
                end
            end
            if (o_valid) begin
                if (n_res < 4) begin
                    chk("b2b_result", o_result, b2b[n_res].res);
                    chk("b2b_flags",  {29'd0, o_cout, o_ovf, o_zero},
                        {29'd0, b2b[n_res].cout, b2b[n_res].ovf, b2b[n_res].zero});
                end
                n_res++;
            end
            if (o_ready && i_valid) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
                adv = 1'b1;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0; i_ready = 1'b0;
        chk("b2b_accepts", n_acc, 4);
        chk("b2b_results", n_res, 4);
        for (int k = 0; k < 3; k++)
            chk("b2b_interval", acc_cyc[k+1] - acc_cyc[k], NIB + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle integer add/subtract unit that processes WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first.
- Uses a 4-bit add/sub slice. The slice carry chains between nibbles through a carry register.
- Serves as the area-lean integer adder for the FPU's exponent and mantissa datapath and for the integer ALU slow path.
- Uses a valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble cycles. Derived; not overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream presents an operation
- o_ready  output  1  block accepts an operation this cycle
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_sub  input  1  0 = A+B, 1 = A−B
- o_valid  output  1  result available
- i_ready  input  1  downstream consumes the result
- o_result  output  WIDTH  sum or difference
- o_cout  output  1  add: carry out. Sub: borrow (1 when A < B unsigned).
- o_ovf  output  1  signed two's-complement overflow
- o_zero  output  1  o_result == 0
- o_busy  output  1  high in RUN or DONE

Behaviour:
- Reset (i_reset high at an edge):
  - state = IDLE; o_valid, o_cout, o_ovf, o_zero, o_busy = 0; o_result = 0; o_ready = 1 after the edge.
  - Reset mid-operation aborts the operation silently. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid && o_ready: latch i_a, i_b, i_sub; set carry register = i_sub; set nibble counter = 0; go to RUN.
  - Inputs are ignored when no transfer occurs.
- RUN:
  - o_ready = 0.
  - Each cycle, nibble k = counter:
    - s = a[4k+3:4k] + (b[4k+3:4k] XOR {4{sub}}) + carry.
    - Write s[3:0] into result[4k+3:4k]; carry <= s[4].
    - Counter increments; after nibble NIB−1, go to DONE.
  - Also on the final nibble, compute the carry into bit WIDTH−1 for overflow.
  - i_valid during RUN has no effect; the operation is not queued.
- DONE:
  - o_valid = 1; o_ready = 0.
  - o_cout = final carry XOR sub.
  - o_ovf = (carry into MSB) XOR (carry out of MSB).
  - o_zero = (result == 0).
  - All outputs are held stable while i_ready = 0.
  - On i_ready, go to IDLE at the next edge and deassert o_valid.
- Latency:
  - Accept at edge T; o_valid is high after edge T+NIB (8 cycles for WIDTH=32).
  - Minimum initiation interval is NIB+2 cycles.
  - No accept occurs in the same cycle as the output handshake.
- Outputs outside DONE:
  - o_result, o_cout, o_ovf and o_zero hold their last values.
  - They are only meaningful while o_valid = 1.
- Boundaries:
  - Unsigned wrap: all-ones + 1 gives result 0, cout 1, zero 1.
  - A−A gives 0, cout 0, zero 1.
  - Simultaneous i_reset and handshake: reset wins.

Test Plan:
1. WIDTH=32, add 0x0000000F + 0x00000001 → result 0x00000010, cout 0, ovf 0, zero 0; o_valid first high exactly 8 cycles after the accept edge.
2. Sub 0x00000005 − 0x00000007 → 0xFFFFFFFE, cout 1 (borrow), ovf 0, zero 0. Then sub 0x12345678 − 0x12345678 → 0x00000000, cout 0, zero 1.
3. Add 0x7FFFFFFF + 0x00000001 → 0x80000000, ovf 1, cout 0. Then add 0xFFFFFFFF + 0x00000001 → 0x00000000, cout 1, ovf 0, zero 1. Then sub 0x80000000 − 0x00000001 → 0x7FFFFFFF, ovf 1.
4. Backpressure: i_ready = 0 for 10 cycles in DONE → o_valid and all result flags constant. Toggling i_valid with new operands meanwhile → o_ready stays 0 and the result is unchanged. i_ready = 1 → o_valid low next cycle, o_ready high.
5. Reset mid-RUN: assert i_reset for 1 cycle at nibble 3 → o_valid never rises for that op; o_ready = 1 next cycle. A following add 0x00000100 + 0x00000200 → 0x00000300 with correct latency.
6. Back-to-back: i_valid held high with 4 queued ops and i_ready tied 1 → each op accepted every NIB+2 cycles, results in order, no dropped or duplicated ops.
